shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 148 ++++++++++++++
 tb/tb_shift_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative one-bit-per-clock shift controller (LLS/LAS/RLS/RAS, 8/16-bit).
// Ports:
//   clk, rst                        clock (rising edge), async active-high reset
//   req_valid/req_ready             request handshake; req_ready only while idle
//   req_op, req_wide                operation (00/01 left, 10 logical right, 11 arith right), width
//   req_data, req_offset            operand and shift amount (upper bits ignored in 8-bit mode)
//   rsp_valid/rsp_ready             response handshake; rsp_valid only in DONE
//   rsp_data, rsp_carry             result and last pushed-out bit
//   busy                            high whenever not idle
module shift_sequencer #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic              req_wide,
   input  logic [DATA_W-1:0] req_data,
   input  logic [CNT_W-1:0]  req_offset,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_carry,
   output logic              busy
);

   localparam int unsigned NARROW_W = DATA_W / 2;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                carry_q, carry_d;
   logic [1:0]          op_q, op_d;
   logic                wide_q, wide_d;
   logic                ovf_q, ovf_d;
   logic                req_ready_q, req_ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                busy_q, busy_d;

   // Request decode: effective width, masked offset, clamped step count, overflow flag
   logic [CNT_W-1:0]    width_c, off_c, k_c;
   logic                ovf_c;
   logic [DATA_W-1:0]   operand_c;

   always_comb begin
      width_c   = req_wide ? CNT_W'(DATA_W) : CNT_W'(NARROW_W);
      off_c     = req_wide ? req_offset : (req_offset & CNT_W'(2 * NARROW_W - 1));
      ovf_c     = off_c > width_c;
      k_c       = ovf_c ? width_c : off_c;
      operand_c = req_wide ? req_data : DATA_W'(req_data[NARROW_W-1:0]);
   end

   // One-bit shift stage; in 8-bit mode the upper byte stays zero
   logic                msb_c, fill_c, push_c;
   logic [DATA_W-1:0]   step_c;

   always_comb begin
      msb_c  = wide_q ? data_q[DATA_W-1] : data_q[NARROW_W-1];
      fill_c = (op_q == 2'b11) ? msb_c : 1'b0;
      if (op_q[1]) begin
         push_c = data_q[0];
         step_c = wide_q ? {fill_c, data_q[DATA_W-1:1]}
                         : DATA_W'({fill_c, data_q[NARROW_W-1:1]});
      end else begin
         push_c = msb_c;
         step_c = wide_q ? {data_q[DATA_W-2:0], 1'b0}
                         : DATA_W'({data_q[NARROW_W-2:0], 1'b0});
      end
   end

   // Next-state and registered-output decode
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      op_d    = op_q;
      wide_d  = wide_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               op_d    = req_op;
               wide_d  = req_wide;
               data_d  = operand_c;
               cnt_d   = k_c;
               ovf_d   = ovf_c;
               carry_d = 1'b0;
               state_d = (k_c == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            data_d  = step_c;
            cnt_d   = cnt_q - CNT_W'(1);
            carry_d = push_c;
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
               // Overflowed shifts report the fill value instead of the last pushed bit
               if (ovf_q) carry_d = fill_c;
            end
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         op_q        <= '0;
         wide_q      <= 1'b0;
         ovf_q       <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         op_q        <= op_d;
         wide_q      <= wide_d;
         ovf_q       <= ovf_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = data_q;
   assign rsp_carry = carry_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed requests push expected results,
// a negedge monitor checks latency, hold stability and the final result.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic        req_wide;
   logic [15:0] req_data;
   logic [4:0]  req_offset;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_carry;
   logic        busy;

   shift_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_wide   (req_wide),
      .req_data   (req_data),
      .req_offset (req_offset),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_carry  (rsp_carry),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        carry;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   bit          seen = 0;
   logic [15:0] held_data;
   logic        held_carry;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: samples on the falling edge, inputs change just after the rising edge
   always @(negedge clk) begin
      if (rst) begin
         seen = 0;
      end else if (rsp_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_data), 32'hDEAD);
         end else begin
            if (!seen) begin
               seen       = 1;
               held_data  = rsp_data;
               held_carry = rsp_carry;
               chk("latency", 32'(cyc), 32'(sb[0].cyc));
            end else begin
               chk("hold_data", 32'(rsp_data), 32'(held_data));
               chk("hold_carry", 32'(rsp_carry), 32'(held_carry));
            end
            chk("ready_in_done", 32'(req_ready), 32'd0);
            chk("busy_in_done", 32'(busy), 32'd1);
            if (rsp_ready) begin
               chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
               chk("rsp_carry", 32'(rsp_carry), 32'(sb[0].carry));
               void'(sb.pop_front());
               seen = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request; k is the expected number of shift steps
   task automatic issue(input logic [1:0] op, input logic wide, input logic [15:0] data,
                        input logic [4:0] off, input logic [15:0] exp_data,
                        input logic exp_carry, input int k, input bit track);
      exp_t e;
      int   n = 0;
      while (!req_ready && n < 100) begin
         tick();
         n++;
      end
      if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
      req_op     = op;
      req_wide   = wide;
      req_data   = data;
      req_offset = off;
      req_valid  = 1'b1;
      if (track) begin
         e.data  = exp_data;
         e.carry = exp_carry;
         e.cyc   = cyc + 1 + k;
         sb.push_back(e);
      end
      tick();
      // Scramble inputs after acceptance; the operation in flight must not care
      req_valid  = 1'b0;
      req_op     = ~op;
      req_wide   = ~wide;
      req_data   = ~data;
      req_offset = ~off;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int n;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_op     = 2'b00;
      req_wide   = 1'b0;
      req_data   = 16'h0;
      req_offset = 5'd0;
      rsp_ready  = 1'b1;
      #12;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", 32'(rsp_data), 32'd0);
      chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("idle_req_ready", 32'(req_ready), 32'd1);

      // op, wide, data, offset, expected data, carry, steps
      issue(2'b00, 1'b0, 16'h0005, 5'd3,  16'h0028, 1'b0, 3,  1);
      issue(2'b00, 1'b0, 16'hFF05, 5'd3,  16'h0028, 1'b0, 3,  1);
      issue(2'b00, 1'b0, 16'h0005, 5'd19, 16'h0028, 1'b0, 3,  1);
      issue(2'b11, 1'b1, 16'h8001, 5'd4,  16'hF800, 1'b0, 4,  1);
      issue(2'b10, 1'b1, 16'hABCD, 5'd0,  16'hABCD, 1'b0, 0,  1);
      issue(2'b00, 1'b1, 16'h8001, 5'd16, 16'h0000, 1'b1, 16, 1);
      issue(2'b00, 1'b1, 16'h8001, 5'd17, 16'h0000, 1'b0, 16, 1);
      issue(2'b11, 1'b0, 16'h0090, 5'd12, 16'h00FF, 1'b1, 8,  1);
      issue(2'b01, 1'b1, 16'h1234, 5'd4,  16'h2340, 1'b1, 4,  1);
      issue(2'b10, 1'b1, 16'h8001, 5'd1,  16'h4000, 1'b1, 1,  1);
      issue(2'b11, 1'b0, 16'h0070, 5'd3,  16'h000E, 1'b0, 3,  1);
      drain();

      // Backpressure: hold rsp_ready low in DONE, pulse a request that must be ignored
      rsp_ready = 1'b0;
      issue(2'b10, 1'b1, 16'h00F0, 5'd4, 16'h000F, 1'b0, 4, 1);
      n = 0;
      while (!rsp_valid && n < 50) begin
         tick();
         n++;
      end
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         req_valid  = (i == 1);
         req_op     = 2'b00;
         req_wide   = 1'b1;
         req_data   = 16'h5555;
         req_offset = 5'd0;
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      chk("bp_idle_after", 32'(req_ready), 32'd1);
      chk("bp_busy_after", 32'(busy), 32'd0);
      repeat (4) tick();
      chk("bp_no_extra", 32'(rsp_valid), 32'd0);
      drain();

      // Asynchronous reset mid-operation
      issue(2'b00, 1'b1, 16'h0001, 5'd15, 16'h0, 1'b0, 15, 0);
      repeat (5) tick();
      chk("mid_busy", 32'(busy), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("async_rsp_data", 32'(rsp_data), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      issue(2'b10, 1'b0, 16'h0080, 5'd7, 16'h0001, 1'b0, 7, 1);
      drain();
      repeat (3) tick();
      chk("final_rsp_valid", 32'(rsp_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
